// File: rtl/ccl_pkg.sv
// Shared definitions for the CCL sequencing controller: state encoding and
// the default position value that closes one length step.
package ccl_pkg;

    localparam logic [1:0] CCL_LOAD = 2'd0;
    localparam logic [1:0] CCL_SCAN = 2'd1;
    localparam logic [1:0] CCL_DONE = 2'd2;

    localparam int CCL_POS_LAST_DEF = 9;

endpackage

// File: rtl/ccl_upcnt.sv
// Parametrised up-counter with synchronous clear, increment enable and a
// compare against a fixed terminal value.
module ccl_upcnt
    import ccl_pkg::*;
#(
    parameter int W    = 2,
    parameter int TERM = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_term
);

    logic [W-1:0] r_cnt;

    // Clear outranks increment so an abort or phase exit always lands on zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == W'(TERM));

endmodule

// File: rtl/ccl_ctr_gen.sv
// Load/scan/done sequencing controller for the DCU character/colour loader:
// drives buffer address and write enable, and the position-counter enable.
module ccl_ctr_gen
    import ccl_pkg::*;
#(
    parameter int N_BYTES  = 4,
    parameter int ADDR_W   = $clog2(N_BYTES),
    parameter int LEN_MAX  = 4,
    parameter int LEN_W    = $clog2(LEN_MAX + 1),
    parameter int POS_W    = 4,
    parameter int POS_LAST = CCL_POS_LAST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_winc,
    input  logic [POS_W-1:0]  i_pos,
    input  logic              i_ack,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_wenb,
    output logic              o_pos_enb,
    output logic              o_pos_end,
    output logic              o_rdy,
    output logic              o_busy,
    output logic              o_ovf
);

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic              r_ovf;
    logic              w_inLoad;
    logic              w_inScan;
    logic              w_inDone;
    logic              w_posEnd;
    logic [ADDR_W-1:0] w_byteCnt;
    logic              w_byteTerm;
    logic [LEN_W-1:0]  w_lenCnt;
    logic              w_lenTerm;
    logic              w_lastWrite;
    logic              w_lastStep;

    assign w_inLoad    = (r_state == CCL_LOAD);
    assign w_inScan    = (r_state == CCL_SCAN);
    assign w_inDone    = (r_state == CCL_DONE);
    assign w_posEnd    = (i_pos == POS_W'(POS_LAST));
    assign w_lastWrite = w_inLoad & i_winc & w_byteTerm;
    assign w_lastStep  = w_inScan & w_posEnd & w_lenTerm;

    ccl_upcnt #(.W(ADDR_W), .TERM(N_BYTES - 1)) u_byteCnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (i_abort | w_lastWrite | (w_inDone & i_ack)),
        .i_inc  (w_inLoad & i_winc),
        .o_cnt  (w_byteCnt),
        .o_term (w_byteTerm)
    );

    // The length counter is always zero in LOAD, so the step into SCAN is a plain increment to 1.
    ccl_upcnt #(.W(LEN_W), .TERM(LEN_MAX)) u_lenCnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (i_abort | w_lastStep),
        .i_inc  ((w_inScan & w_posEnd) | w_lastWrite),
        .o_cnt  (w_lenCnt),
        .o_term (w_lenTerm)
    );

    always_comb begin
        w_nextState = r_state;
        if (i_abort) begin
            w_nextState = CCL_LOAD;
        end else begin
            case (r_state)
                CCL_LOAD: if (w_lastWrite)  w_nextState = CCL_SCAN;
                CCL_SCAN: if (w_lastStep)   w_nextState = CCL_DONE;
                CCL_DONE: if (i_ack)        w_nextState = CCL_LOAD;
                default:                    w_nextState = CCL_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CCL_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A stray write outside LOAD is only flagged; ack in DONE wins over a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (i_abort) begin
            r_ovf <= 1'b0;
        end else if (w_inDone & i_ack) begin
            r_ovf <= 1'b0;
        end else if (i_winc & ~w_inLoad) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_buf_addr = w_inLoad ? w_byteCnt : '0;
    assign o_len      = w_inScan ? w_lenCnt : '0;
    assign o_wenb     = w_inLoad & i_winc & ~i_abort & ~rst;
    assign o_pos_enb  = w_inScan;
    assign o_busy     = w_inScan;
    assign o_rdy      = w_inDone;
    assign o_pos_end  = w_posEnd;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_ccl_ctr_gen.sv
// Self-checking bench for ccl_ctr_gen: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_ccl_ctr_gen;

    localparam int NB = 4;
    localparam int LM = 4;
    localparam int PL = 9;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       winc  = 1'b0;
    logic       ack   = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pos   = 4'd0;

    logic [1:0] buf_addr;
    logic [2:0] len;
    logic       wenb;
    logic       pos_enb;
    logic       pos_end;
    logic       rdy;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    typedef enum {PH_FILL, PH_SWEEP, PH_READY} phase_e;
    phase_e mPhase;
    int     mWritten;
    int     mLen;
    bit     mOvf;

    ccl_ctr_gen #(
        .N_BYTES  (NB),
        .LEN_MAX  (LM),
        .POS_W    (4),
        .POS_LAST (PL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_winc     (winc),
        .i_pos      (pos),
        .i_ack      (ack),
        .i_abort    (abort),
        .o_buf_addr (buf_addr),
        .o_len      (len),
        .o_wenb     (wenb),
        .o_pos_enb  (pos_enb),
        .o_pos_end  (pos_end),
        .o_rdy      (rdy),
        .o_busy     (busy),
        .o_ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mPhase   = PH_FILL;
        mWritten = 0;
        mLen     = 0;
        mOvf     = 1'b0;
    endfunction

    // Frame-level model: counts bytes written and length steps completed.
    function automatic void model_step();
        if (abort) begin
            model_reset();
        end else begin
            case (mPhase)
                PH_FILL: begin
                    if (winc) begin
                        mWritten++;
                        if (mWritten == NB) begin
                            mPhase   = PH_SWEEP;
                            mWritten = 0;
                            mLen     = 1;
                        end
                    end
                end
                PH_SWEEP: begin
                    if (winc) mOvf = 1'b1;
                    if (pos == PL) begin
                        if (mLen == LM) begin
                            mPhase = PH_READY;
                            mLen   = 0;
                        end else begin
                            mLen++;
                        end
                    end
                end
                default: begin
                    if (ack) begin
                        mPhase = PH_FILL;
                        mOvf   = 1'b0;
                    end else if (winc) begin
                        mOvf = 1'b1;
                    end
                end
            endcase
        end
    endfunction

    task automatic set_in(input logic w, input logic [3:0] p, input logic a, input logic ab);
        @(negedge clk);
        winc  = w;
        pos   = p;
        ack   = a;
        abort = ab;
        #1;
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 4'd9, 1'b0, 1'b0);
        checks++;
        if ({buf_addr, len, wenb, pos_enb, rdy, busy, ovf} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected 0", {buf_addr, len, wenb, pos_enb, rdy, busy, ovf});
        end
        checks++;
        if (pos_end !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_pos_end: got %b expected 1", pos_end);
        end
        @(negedge clk);
        rst  = 1'b0;
        winc = 1'b0;
        model_reset();
    endtask

    task automatic test_load();
        for (int i = 0; i < NB; i++) begin
            set_in(1'b1, 4'd0, 1'b0, 1'b0);
            checks++;
            if (wenb !== 1'b1 || buf_addr !== 2'(i)) begin
                failures++;
                $display("[TB] FAIL load_write%0d: got wenb=%b addr=%0d expected wenb=1 addr=%0d", i, wenb, buf_addr, i);
            end
            adv();
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || len !== 3'd1 || pos_enb !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_enter_scan: got busy=%b len=%0d pos_enb=%b expected 1/1/1", busy, len, pos_enb);
        end
    endtask

    task automatic test_scan();
        int  expLen = 1;
        bit  done   = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            set_in(1'b0, 4'(c % 10), 1'b0, 1'b0);
            if (expLen > LM) begin
                checks++;
                if (rdy !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL scan_rdy: got rdy=%b busy=%b expected 1/0", rdy, busy);
                end
                done = 1'b1;
            end else begin
                checks++;
                if (len !== 3'(expLen) || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL scan_len c=%0d: got len=%0d busy=%b expected len=%0d busy=1", c, len, busy, expLen);
                end
                adv();
                if (c % 10 == PL) expLen++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL scan_timeout: got no rdy expected rdy within 60 cycles");
        end
        for (int h = 0; h < 20; h++) begin
            adv();
            set_in(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL done_hold%0d: got rdy=%b expected 1", h, rdy);
            end
        end
    endtask

    task automatic test_ack();
        set_in(1'b0, 4'd0, 1'b1, 1'b0);
        adv();
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        checks++;
        if (rdy !== 1'b0 || wenb !== 1'b1 || buf_addr !== 2'd0) begin
            failures++;
            $display("[TB] FAIL ack_rearm: got rdy=%b wenb=%b addr=%0d expected 0/1/0", rdy, wenb, buf_addr);
        end
        adv();
        for (int i = 1; i < NB; i++) begin
            set_in(1'b1, 4'd0, 1'b0, 1'b0);
            adv();
        end
    endtask

    task automatic test_ovf();
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        checks++;
        if (wenb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_wenb: got %b expected 0", wenb);
        end
        adv();
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1 || len !== 3'd1) begin
            failures++;
            $display("[TB] FAIL ovf_set: got ovf=%b len=%0d expected 1/1", ovf, len);
        end
        for (int i = 0; i < LM; i++) begin
            set_in(1'b0, 4'(PL), 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, 4'd0, 1'b1, 1'b0);
        checks++;
        if (rdy !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_in_done: got rdy=%b ovf=%b expected 1/1", rdy, ovf);
        end
        adv();
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b0 || rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear: got ovf=%b rdy=%b expected 0/0", ovf, rdy);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NB; i++) begin
            set_in(1'b1, 4'd0, 1'b0, 1'b0);
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 4'(PL), 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, 4'(PL), 1'b0, 1'b1);
        checks++;
        if (len !== 3'd3 || pos_end !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_pre: got len=%0d pos_end=%b expected 3/1", len, pos_end);
        end
        adv();
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (len !== 3'd0 || pos_enb !== 1'b0 || buf_addr !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_scan: got len=%0d pos_enb=%b addr=%0d busy=%b expected 0/0/0/0", len, pos_enb, buf_addr, busy);
        end
        for (int i = 0; i < NB - 1; i++) begin
            set_in(1'b1, 4'd0, 1'b0, 1'b0);
            adv();
        end
        set_in(1'b1, 4'd0, 1'b0, 1'b1);
        checks++;
        if (wenb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_wenb: got %b expected 0", wenb);
        end
        adv();
        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || buf_addr !== 2'd0) begin
            failures++;
            $display("[TB] FAIL abort_last_write: got busy=%b addr=%0d expected 0/0", busy, buf_addr);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NB; i++) begin
            set_in(1'b1, 4'd0, 1'b0, 1'b0);
            adv();
        end
        set_in(1'b0, 4'd9, 1'b0, 1'b0);
        adv();
        set_in(1'b0, 4'd9, 1'b0, 1'b0);
        checks++;
        if (pos_enb !== 1'b1 || len !== 3'd2) begin
            failures++;
            $display("[TB] FAIL arst_pre: got pos_enb=%b len=%0d expected 1/2", pos_enb, len);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({buf_addr, len, wenb, pos_enb, rdy, busy, ovf} !== 10'd0 || pos_end !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arst_outputs: got %b pos_end=%b expected 0 and 1", {buf_addr, len, wenb, pos_enb, rdy, busy, ovf}, pos_end);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        checks++;
        if (wenb !== 1'b1 || buf_addr !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arst_release: got wenb=%b addr=%0d busy=%b expected 1/0/0", wenb, buf_addr, busy);
        end
        adv();
    endtask

    task automatic test_random();
        logic [10:0] expV;
        logic [10:0] actV;
        int          posCnt = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 7) posCnt = (posCnt + 1) % 10;
            set_in(1'($urandom_range(0, 9) < 4),
                   ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(posCnt),
                   1'($urandom_range(0, 9) < 2),
                   1'($urandom_range(0, 99) < 3));
            expV = {(mPhase == PH_FILL) ? 2'(mWritten) : 2'd0,
                    (mPhase == PH_SWEEP) ? 3'(mLen) : 3'd0,
                    (mPhase == PH_FILL) && winc && !abort,
                    mPhase == PH_SWEEP,
                    pos == PL,
                    mPhase == PH_READY,
                    mPhase == PH_SWEEP,
                    mOvf};
            actV = {buf_addr, len, wenb, pos_enb, pos_end, rdy, busy, ovf};
            checks++;
            if (actV !== expV) begin
                failures++;
                $display("[TB] FAIL random_c%0d: got %b expected %b (addr,len,wenb,pos_enb,pos_end,rdy,busy,ovf)", c, actV, expV);
            end
            adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_scan();
        test_ack();
        test_ovf();
        test_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
